// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - iterative radix-4 Booth multiplier sharing one 66-bit CLA
module CLA #(
   parameter int W = 66
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum
);
   logic [W-1:0] p0, gp, pp, gn, pn, carry;

   // Kogge-Stone prefix over (g, p); cin folds in after the prefix
   always_comb begin
      p0    = a ^ b;
      gp    = a & b;
      pp    = p0;
      gn    = '0;
      pn    = '0;
      carry = '0;
      for (int s = 1; s < W; s = s * 2) begin
         for (int i = 0; i < W; i++) begin
            if (i >= s) begin
               gn[i] = gp[i] | (pp[i] & gp[i-s]);
               pn[i] = pp[i] & pp[i-s];
            end else begin
               gn[i] = gp[i];
               pn[i] = pp[i];
            end
         end
         gp = gn;
         pp = pn;
      end
      carry[0] = cin;
      for (int i = 1; i < W; i++) begin
         carry[i] = gp[i-1] | (pp[i-1] & cin);
      end
      sum = p0 ^ carry;
   end
endmodule

module booth_mul_seq #(
   parameter int XLEN      = 32,
   parameter bit ZERO_SKIP = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     a,
   input  logic [XLEN-1:0]     b,
   input  logic                a_signed,
   input  logic                b_signed,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*XLEN-1:0]   result,
   output logic                busy
);
   localparam int AW   = 2 * XLEN + 2;
   localparam int YW   = XLEN + 3;
   localparam int CW   = $clog2(XLEN / 2 + 1);
   localparam logic [CW-1:0] LAST = CW'(XLEN / 2);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   x_q, acc_q, mult, opb, sum;
   logic [YW-1:0]   y_q;
   logic [CW-1:0]   cnt_q;
   logic            neg;
   logic            zero_op;
   logic [AW-1:0]   a_ext;
   logic [YW-1:0]   y_init;

   assign a_ext   = {{(AW-XLEN){a_signed & a[XLEN-1]}}, a};
   assign y_init  = {{2{b_signed & b[XLEN-1]}}, b, 1'b0};
   assign zero_op = ZERO_SKIP && ((a == '0) || (b == '0));

   // Booth digit select from the low three bits of the multiplier shift register
   always_comb begin
      mult = '0;
      neg  = 1'b0;
      case (y_q[2:0])
         3'b001, 3'b010: mult = x_q;
         3'b011:         mult = {x_q[AW-2:0], 1'b0};
         3'b100: begin
            mult = {x_q[AW-2:0], 1'b0};
            neg  = 1'b1;
         end
         3'b101, 3'b110: begin
            mult = x_q;
            neg  = 1'b1;
         end
         default: ;
      endcase
      opb = neg ? ~mult : mult;
   end

   CLA #(.W(AW)) u_cla (
      .a   (acc_q),
      .b   (opb),
      .cin (neg),
      .sum (sum)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (in_valid) state_d = zero_op ? S_DONE : S_BUSY;
         S_BUSY: if (cnt_q == LAST) state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q   <= '0;
         y_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               x_q   <= a_ext;
               y_q   <= y_init;
               acc_q <= '0;
               cnt_q <= '0;
            end
            S_BUSY: begin
               acc_q <= sum;
               x_q   <= {x_q[AW-3:0], 2'b00};
               y_q   <= {{2{y_q[YW-1]}}, y_q[YW-1:2]};
               cnt_q <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign result    = acc_q[2*XLEN-1:0];
endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Iterative radix-4 Booth multiplier controller that time-shares one 66-bit carry-lookahead adder instance (module CLA) to form a 32x32 -> 64-bit product.
- Sequences operand recoding, partial-product selection, and accumulation over 17 cycles.
- Exposes valid/ready handshakes on the request and result sides.
- Sits between the execute-stage issue logic and writeback, as the area-optimised alternative to the tree multiplier.

Parameters:
- XLEN, 32, operand width; only legal value is 32 (adder width 2*XLEN+2 = 66).
- ZERO_SKIP, 1, when 1 a zero operand bypasses iteration and completes in 1 cycle.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort: drops in-flight or completed op, returns to IDLE.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- a  in  32  multiplicand.
- b  in  32  multiplier.
- a_signed  in  1  1 = a is two's complement, 0 = unsigned.
- b_signed  in  1  1 = b is two's complement, 0 = unsigned.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  64  product, low 64 bits of the 66-bit accumulator.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, accumulator=0, counter=0.
- Reset has priority over flush; flush has priority over all other events.
- States are IDLE, BUSY and DONE.
  - IDLE: in_ready=1. On in_valid:
    - latch X = a extended to 66 bits (sign-extended if a_signed, else zero-extended);
    - latch Y shift register = {b extended to 34 bits by signedness, 1'b0} (35 bits);
    - clear accumulator and counter; go to BUSY.
  - ZERO_SKIP=1 and (a==0 or b==0) on accept: go directly to DONE with accumulator=0 (out_valid on the next cycle).
- BUSY, one Booth group per cycle:
  - Group is Y[2:0]. Encoding: 000/111 -> 0; 001/010 -> +X; 011 -> +2X; 100 -> -2X; 101/110 -> -X.
  - Adder operand A = accumulator. Operand B = selected multiple, bitwise-inverted when negative. cin = 1 when negative, else 0.
  - accumulator <= adder sum (mod 2^66; cout ignored).
  - X <= X << 2. Y <= Y arithmetic-shift-right by 2. counter++.
  - After counter==16 completes (17 iterations), go to DONE.
- DONE: out_valid=1 and result=accumulator[63:0], both stable until out_ready. On out_ready, go to IDLE in the next cycle.
  - No new request is accepted in the same cycle as out_ready; in_ready rises the following cycle.
- Latency: request accepted at edge T, out_valid high after edge T+18 (17 BUSY cycles + DONE entry). With zero-skip, out_valid is high after edge T+1.
- in_valid while not IDLE is ignored; a, b and the sign flags are not sampled.
- The adder is driven every cycle. Its outputs are consumed only in BUSY.
- flush in any state:
  - next state IDLE, out_valid=0, accumulator cleared;
  - a request presented in the same cycle as flush is not accepted.
- reset mid-operation: identical to reset values; partial result discarded.
- Throughput: at most one product per 19 cycles with out_ready tied high.

Test Plan:
- Unsigned a=3, b=5 -> out_valid exactly 18 cycles after accept, result=0x000000000000000F.
- Signed edge cases:
  - a=0x80000000, b=0x80000000, both signed -> result=0x4000000000000000;
  - a=b=0xFFFFFFFF, both signed -> result=0x0000000000000001.
- Unsigned max: a=b=0xFFFFFFFF, both unsigned -> result=0xFFFFFFFE00000001.
- Mixed signedness: a=0xFFFFFFFF signed, b=0xFFFFFFFF unsigned -> result=0xFFFFFFFF00000001.
- Zero skip and backpressure:
  - ZERO_SKIP=1, a=0, b=0x1234 -> out_valid 1 cycle after accept, result=0;
  - hold out_ready=0 for 10 cycles -> result stable, in_ready=0 throughout.
- Abort and random check:
  - flush asserted at BUSY cycle 7 -> IDLE next cycle, out_valid never rises;
  - reset at BUSY cycle 7 -> all outputs at reset values;
  - back-to-back random 10k ops vs reference model (signed/unsigned mixes) -> bit-exact match.
